// File: rtl/mig_seq_pkg.sv
// Shared types and default geometry for the MIG sequential evaluator.
// The operand/gate structs are sized for the default NUM_IN/MAX_GATES geometry.
package mig_seq_pkg;

    localparam int unsigned NumInDef    = 6;
    localparam int unsigned MaxGatesDef = 16;
    localparam int unsigned IdxWDef     = $clog2(NumInDef + 1 + MaxGatesDef);

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    typedef struct packed {
        logic               c;
        logic [IdxWDef-1:0] idx;
    } operand_t;

    // op[2] sits in the MSBs, so the packed layout is {c2,i2,c1,i1,c0,i0}.
    typedef struct packed {
        operand_t [2:0] op;
    } gate_t;

endpackage

// File: rtl/maj3_unit.sv
// Combinational 3-input majority with a complement bit per input.
module maj3_unit (
    input  logic [2:0] i_a,
    input  logic [2:0] i_c,
    output logic       o_maj
);

    logic [2:0] w_v;

    assign w_v   = i_a ^ i_c;
    assign o_maj = (w_v[0] & w_v[1]) | (w_v[0] & w_v[2]) | (w_v[1] & w_v[2]);

endmodule

// File: rtl/mig_seq_eval.sv
// Time-multiplexed MIG evaluator: one MAJ3 gate per cycle from a reprogrammable gate RAM.
// Define MIG_SEQ_CHK_EN to build the operand/output index checker that drives o_err.
module mig_seq_eval
    import mig_seq_pkg::*;
#(
    parameter  int unsigned NUM_IN    = NumInDef,
    parameter  int unsigned MAX_GATES = MaxGatesDef,
    localparam int unsigned IDX_W     = $clog2(NUM_IN + 1 + MAX_GATES),
    localparam int unsigned AW        = $clog2(MAX_GATES),
    localparam int unsigned NW        = $clog2(MAX_GATES + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_prog_we,
    input  logic [AW-1:0]          i_prog_addr,
    input  logic [3*(IDX_W+1)-1:0] i_prog_data,
    input  logic                   i_cfg_we,
    input  logic [NW-1:0]          i_cfg_num_gates,
    input  logic [IDX_W-1:0]       i_cfg_out_idx,
    input  logic                   i_cfg_out_c,
    input  logic                   i_start,
    input  logic [NUM_IN-1:0]      i_x,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_y,
    output logic                   o_err
);

    localparam int unsigned    XW       = $clog2(NUM_IN);
    localparam logic [IDX_W:0] GateBase = (IDX_W + 1)'(NUM_IN + 1);

    state_e               r_state, w_state_next;
    gate_t                r_prog [MAX_GATES];
    gate_t                w_gate;
    logic [MAX_GATES-1:0] r_node;
    logic [NUM_IN-1:0]    r_x;
    logic [AW-1:0]        r_g;
    logic [NW-1:0]        r_num, w_num_new;
    logic [IDX_W-1:0]     r_out_idx;
    logic                 r_out_c, r_y, r_done;
    logic                 w_idle, w_accept, w_last, w_maj;
    logic [IDX_W:0]       w_lim_eval, w_lim_done;
    logic [2:0]           w_opv, w_opc;

    // Gate nodes at or above lim are not yet defined in this run and read as 0.
    function automatic logic node_rd(input logic [IDX_W-1:0]     idx,
                                     input logic [IDX_W:0]       lim,
                                     input logic [NUM_IN-1:0]    xv,
                                     input logic [MAX_GATES-1:0] nv);
        logic [IDX_W:0] w_i;
        w_i = {1'b0, idx};
        if (idx == '0 || w_i >= lim) return 1'b0;
        if (w_i < GateBase) return xv[XW'(idx - IDX_W'(1))];
        return nv[AW'(w_i - GateBase)];
    endfunction

    assign w_idle     = (r_state == StIdle);
    assign w_accept   = w_idle & i_start;
    assign w_last     = (NW'(r_g) + NW'(1)) == r_num;
    assign w_gate     = r_prog[r_g];
    assign w_lim_eval = GateBase + (IDX_W + 1)'(r_g);
    assign w_lim_done = GateBase + (IDX_W + 1)'(r_num);

    always_comb begin
        w_num_new = r_num;
        if (i_cfg_we) begin
            w_num_new = (i_cfg_num_gates > NW'(MAX_GATES)) ? NW'(MAX_GATES) : i_cfg_num_gates;
        end
    end

    always_comb begin
        w_opv = '0;
        w_opc = '0;
        for (int j = 0; j < 3; j++) begin
            w_opv[j] = node_rd(w_gate.op[j].idx, w_lim_eval, r_x, r_node);
            w_opc[j] = w_gate.op[j].c;
        end
    end

    maj3_unit u_maj3 (
        .i_a   (w_opv),
        .i_c   (w_opc),
        .o_maj (w_maj)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= StIdle;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = (w_num_new == '0) ? StDone : StEval;
            StEval:  if (w_last) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // busy covers the done cycle too, so a run occupies cfg_num_gates+2 cycles.
    always_comb begin
        o_busy = (r_state != StIdle) | r_done;
        o_done = r_done;
        o_y    = r_y;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_g       <= '0;
            r_num     <= '0;
            r_out_idx <= '0;
            r_out_c   <= 1'b0;
            r_y       <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_idle && i_cfg_we) begin
                r_num     <= w_num_new;
                r_out_idx <= i_cfg_out_idx;
                r_out_c   <= i_cfg_out_c;
            end
            if (w_accept)                r_g <= '0;
            else if (r_state == StEval) r_g <= r_g + AW'(1);
            if (r_state == StDone) begin
                r_y    <= node_rd(r_out_idx, w_lim_done, r_x, r_node) ^ r_out_c;
                r_done <= 1'b1;
            end
        end
    end

    // Program RAM and node storage are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_idle && i_prog_we) r_prog[i_prog_addr] <= i_prog_data;
        if (w_accept)                      r_x <= i_x;
        if (r_state == StEval)             r_node[r_g] <= w_maj;
    end

`ifdef MIG_SEQ_CHK_EN
    logic r_err, w_err_set;

    always_comb begin
        w_err_set = 1'b0;
        if (r_state == StEval) begin
            for (int j = 0; j < 3; j++) begin
                if ({1'b0, w_gate.op[j].idx} >= w_lim_eval) w_err_set = 1'b1;
            end
        end
        if (r_state == StDone && {1'b0, r_out_idx} >= w_lim_done) w_err_set = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst)          r_err <= 1'b0;
        else if (w_err_set) r_err <= 1'b1;
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_mig_seq_eval.sv
// Self-checking bench for mig_seq_eval: directed and randomized runs against an
// array-based MIG model; expects err only when built with MIG_SEQ_CHK_EN.
module tb_mig_seq_eval;

    localparam int NI = 6;
    localparam int MG = 16;
    localparam int IW = $clog2(NI + 1 + MG);
    localparam int AW = $clog2(MG);
    localparam int NW = $clog2(MG + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                prog_we = 1'b0;
    logic [AW-1:0]       prog_addr = '0;
    logic [3*(IW+1)-1:0] prog_data = '0;
    logic                cfg_we = 1'b0;
    logic [NW-1:0]       cfg_num_gates = '0;
    logic [IW-1:0]       cfg_out_idx = '0;
    logic                cfg_out_c = 1'b0;
    logic                start = 1'b0;
    logic [NI-1:0]       x = '0;
    logic                busy, done, y, err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference program/config as plain arrays
    int m_idx [MG][3];
    bit m_c   [MG][3];
    int m_num;
    int m_out_idx;
    bit m_out_c;

    always #5 clk = ~clk;

    mig_seq_eval dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_prog_we       (prog_we),
        .i_prog_addr     (prog_addr),
        .i_prog_data     (prog_data),
        .i_cfg_we        (cfg_we),
        .i_cfg_num_gates (cfg_num_gates),
        .i_cfg_out_idx   (cfg_out_idx),
        .i_cfg_out_c     (cfg_out_c),
        .i_start         (start),
        .i_x             (x),
        .o_busy          (busy),
        .o_done          (done),
        .o_y             (y),
        .o_err           (err)
    );

    function automatic bit model_eval(input logic [NI-1:0] xv);
        bit nodes [NI+1+MG];
        int n;
        int ones;
        bit v;
        n = (m_num > MG) ? MG : m_num;
        for (int i = 0; i < NI + 1 + MG; i++) nodes[i] = 1'b0;
        for (int i = 1; i <= NI; i++) nodes[i] = xv[i-1];
        for (int k = 0; k < n; k++) begin
            ones = 0;
            for (int j = 0; j < 3; j++) begin
                v = (m_idx[k][j] < NI + 1 + k) ? nodes[m_idx[k][j]] : 1'b0;
                ones += int'(v ^ m_c[k][j]);
            end
            nodes[NI+1+k] = (ones >= 2);
        end
        return ((m_out_idx < NI + 1 + n) ? nodes[m_out_idx] : 1'b0) ^ m_out_c;
    endfunction

    function automatic int model_lat();
        return ((m_num > MG) ? MG : m_num) + 1;
    endfunction

    task automatic drive_gate(input int k, input int i0, input int i1, input int i2,
                              input bit c0, input bit c1, input bit c2);
        prog_addr = AW'(k);
        prog_data = {c2, IW'(i2), c1, IW'(i1), c0, IW'(i0)};
        prog_we   = 1'b1;
    endtask

    task automatic model_gate(input int k, input int i0, input int i1, input int i2,
                              input bit c0, input bit c1, input bit c2);
        m_idx[k][0] = i0; m_idx[k][1] = i1; m_idx[k][2] = i2;
        m_c[k][0]   = c0; m_c[k][1]   = c1; m_c[k][2]   = c2;
    endtask

    task automatic write_gate(input int k, input int i0, input int i1, input int i2,
                              input bit c0, input bit c1, input bit c2);
        drive_gate(k, i0, i1, i2, c0, c1, c2);
        @(posedge clk); #1;
        prog_we = 1'b0;
        model_gate(k, i0, i1, i2, c0, c1, c2);
    endtask

    task automatic set_cfg(input int n, input int oidx, input bit oc);
        cfg_num_gates = NW'(n);
        cfg_out_idx   = IW'(oidx);
        cfg_out_c     = oc;
        cfg_we        = 1'b1;
        @(posedge clk); #1;
        cfg_we    = 1'b0;
        m_num     = n;
        m_out_idx = oidx;
        m_out_c   = oc;
    endtask

    task automatic load_tanh();
        write_gate(0, 1, 2, 3, 0, 0, 1);
        write_gate(1, 2, 5, 7, 0, 0, 0);
        write_gate(2, 1, 6, 8, 0, 0, 1);
        write_gate(3, 0, 6, 9, 0, 0, 0);
        write_gate(4, 4, 5, 10, 1, 0, 0);
        set_cfg(5, 11, 0);
    endtask

    // Called right after the edge that accepted start (m0 = cycles already elapsed).
    task automatic wait_result(input int m0, output logic yv, output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        yv   = 1'bx;
        for (int m = m0; m < m0 + 64; m++) begin
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                lat = m;
                yv  = y;
            end
            if (busy !== 1'b1) break;
            @(posedge clk); #1;
        end
    endtask

    task automatic run_eval(input logic [NI-1:0] xv, output logic yv, output int lat,
                            output int bcnt);
        x     = xv;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_result(0, yv, lat, bcnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks += 4;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        if (y !== 1'b0)    begin n_fail++; $display("FAIL reset_y: got %b want 0", y); end
        if (err !== 1'b0)  begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
    endtask

    task automatic test_tanh_basic();
        logic yv;
        int   lat, bc;
        load_tanh();
        run_eval(6'h00, yv, lat, bc);
        n_checks += 2;
        if (yv !== 1'b0) begin n_fail++; $display("FAIL tanh_x00_y: got %b want 0", yv); end
        if (lat != 6)    begin n_fail++; $display("FAIL tanh_x00_lat: got %0d want 6", lat); end
        run_eval(6'h10, yv, lat, bc);
        n_checks += 2;
        if (yv !== 1'b1) begin n_fail++; $display("FAIL tanh_x10_y: got %b want 1", yv); end
        if (lat != 6)    begin n_fail++; $display("FAIL tanh_x10_lat: got %0d want 6", lat); end
    endtask

    task automatic test_exhaustive();
        logic yv;
        bit   ev;
        int   lat, bc;
        load_tanh();
        for (int v = 0; v < 64; v++) begin
            ev = model_eval(NI'(v));
            run_eval(NI'(v), yv, lat, bc);
            n_checks += 3;
            if (yv !== ev) begin
                n_fail++; $display("FAIL exh_y x=%0h: got %b want %b", v, yv, ev);
            end
            if (bc != 7) begin
                n_fail++; $display("FAIL exh_busy x=%0h: got %0d cycles want 7", v, bc);
            end
            if (lat != 6) begin
                n_fail++; $display("FAIL exh_lat x=%0h: got %0d want 6", v, lat);
            end
        end
    endtask

    task automatic test_zero_gates();
        logic yv;
        int   lat, bc;
        set_cfg(0, 3, 1);
        run_eval(6'h04, yv, lat, bc);
        n_checks += 3;
        if (yv !== 1'b0) begin n_fail++; $display("FAIL zero_y: got %b want 0", yv); end
        if (lat != 1)    begin n_fail++; $display("FAIL zero_lat: got %0d want 1", lat); end
        if (bc != 2)     begin n_fail++; $display("FAIL zero_busy: got %0d want 2", bc); end
    endtask

    task automatic test_same_cycle_write();
        logic yv;
        bit   ev;
        int   lat, bc;
        load_tanh();
        // gate 4 becomes MAJ(~0, x0, x0) = x0, output complemented
        drive_gate(4, 0, 1, 1, 1, 0, 0);
        cfg_num_gates = NW'(5);
        cfg_out_idx   = IW'(11);
        cfg_out_c     = 1'b1;
        cfg_we        = 1'b1;
        x             = 6'h00;
        start         = 1'b1;
        @(posedge clk); #1;
        prog_we = 1'b0;
        cfg_we  = 1'b0;
        start   = 1'b0;
        model_gate(4, 0, 1, 1, 1, 0, 0);
        m_out_c = 1'b1;
        ev = model_eval(6'h00);
        wait_result(0, yv, lat, bc);
        n_checks += 2;
        if (yv !== ev) begin n_fail++; $display("FAIL same_cycle_y: got %b want %b", yv, ev); end
        if (lat != 6)  begin n_fail++; $display("FAIL same_cycle_lat: got %0d want 6", lat); end
    endtask

    task automatic test_drop_in_eval();
        logic yv;
        bit   ev;
        int   lat, bc;
        load_tanh();
        ev    = model_eval(6'h10);
        x     = 6'h10;
        start = 1'b1;
        @(posedge clk); #1;
        // in EVAL now: these must all be ignored
        drive_gate(4, 0, 0, 0, 0, 0, 0);
        cfg_num_gates = '0;
        cfg_out_c     = 1'b1;
        cfg_we        = 1'b1;
        x             = 6'h00;
        @(posedge clk); #1;
        start   = 1'b0;
        prog_we = 1'b0;
        cfg_we  = 1'b0;
        wait_result(1, yv, lat, bc);
        n_checks += 2;
        if (yv !== ev) begin n_fail++; $display("FAIL drop_y: got %b want %b", yv, ev); end
        if (lat != 6)  begin n_fail++; $display("FAIL drop_lat: got %0d want 6", lat); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_no_queue: busy %b want 0", busy); end
        run_eval(6'h10, yv, lat, bc);
        n_checks += 2;
        if (yv !== ev) begin n_fail++; $display("FAIL drop_rerun_y: got %b want %b", yv, ev); end
        if (lat != 6)  begin n_fail++; $display("FAIL drop_rerun_lat: got %0d want 6", lat); end
    endtask

    task automatic test_reset_mid();
        logic yv;
        int   lat, bc;
        int   pulses;
        load_tanh();
        run_eval(6'h10, yv, lat, bc);
        x     = 6'h10;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks += 3;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (y !== 1'b0)    begin n_fail++; $display("FAIL rstmid_y: got %b want 0", y); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (pulses != 0) begin n_fail++; $display("FAIL rstmid_pulse: got %0d want 0", pulses); end
        set_cfg(5, 11, 0);
        run_eval(6'h10, yv, lat, bc);
        n_checks++;
        if (yv !== model_eval(6'h10)) begin
            n_fail++; $display("FAIL rstmid_prog_kept: got %b want %b", yv, model_eval(6'h10));
        end
    endtask

    task automatic test_random();
        logic          yv;
        bit            ev;
        int            lat, bc, ia, ib, ic;
        logic [NI-1:0] xv;
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < MG; k++) begin
                ia = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NI + k);
                ib = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NI + k);
                ic = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, NI + k);
                write_gate(k, ia, ib, ic, 1'($urandom), 1'($urandom), 1'($urandom));
            end
            set_cfg($urandom_range(0, 20), $urandom_range(0, 31), 1'($urandom));
            for (int v = 0; v < 8; v++) begin
                xv = NI'($urandom);
                ev = model_eval(xv);
                run_eval(xv, yv, lat, bc);
                n_checks += 2;
                if (yv !== ev) begin
                    n_fail++;
                    $display("FAIL rand_y p=%0d n=%0d x=%0h: got %b want %b", p, m_num, xv, yv, ev);
                end
                if (lat != model_lat()) begin
                    n_fail++;
                    $display("FAIL rand_lat p=%0d n=%0d: got %0d want %0d", p, m_num, lat,
                             model_lat());
                end
            end
        end
    endtask

    task automatic test_err();
        logic yv;
        int   lat, bc;
        logic exp_err;
`ifdef MIG_SEQ_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        load_tanh();
        write_gate(1, 2, 5, 9, 0, 0, 0);
        x     = 6'h15;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_g1: got %b want 0", err); end
        @(posedge clk); #1;
        n_checks++;
        if (err !== exp_err) begin n_fail++; $display("FAIL err_g2: got %b want %b", err, exp_err); end
        wait_result(2, yv, lat, bc);
        repeat (3) begin @(posedge clk); #1; end
        n_checks += 2;
        if (err !== exp_err) begin
            n_fail++; $display("FAIL err_sticky: got %b want %b", err, exp_err);
        end
        if (yv !== model_eval(6'h15)) begin
            n_fail++; $display("FAIL err_y: got %b want %b", yv, model_eval(6'h15));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_rst: got %b want 0", err); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_tanh_basic();
        test_exhaustive();
        test_zero_gates();
        test_same_cycle_write();
        test_drop_in_eval();
        test_reset_mid();
        test_random();
        test_err();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
